// File: rtl/data_memory_responder.sv
// Fixed-latency 64-bit little-endian data memory for the Y86 memory stage.
// Define DMEM_ALIGN_CHECK_EN to flag accesses whose location is not 8-byte aligned as errors.
module data_memory_responder #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        read_En,
    input  logic        write_En,
    input  logic [63:0] location,
    input  logic [63:0] wdata,
    output logic        rsp_valid,
    output logic [63:0] rdata,
    output logic        data_memerror
);

    localparam int unsigned AW      = $clog2(MEM_BYTES);
    localparam logic [63:0] LAST_OK = 64'(MEM_BYTES - 8);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_rd;
    logic        r_wr;
    logic [63:0] r_loc;
    logic [63:0] r_wdata;
    logic        r_rsp_valid;
    logic [63:0] r_rdata;
    logic        r_err;

    logic [7:0]  r_mem [MEM_BYTES];

    logic        w_src_rd;
    logic        w_src_wr;
    logic [63:0] w_src_loc;
    logic        w_err;
    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_wr_idx;
    logic [63:0] w_rd_data;

    // In IDLE the response is formed straight from the inputs so LATENCY=1 can skip BUSY.
    assign w_src_rd  = (r_state == StIdle) ? read_En  : r_rd;
    assign w_src_wr  = (r_state == StIdle) ? write_En : r_wr;
    assign w_src_loc = (r_state == StIdle) ? location : r_loc;

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_err = (w_src_loc > LAST_OK) || (w_src_rd && w_src_wr) || (w_src_loc[2:0] != 3'd0);
`else
    assign w_err = (w_src_loc > LAST_OK) || (w_src_rd && w_src_wr);
`endif

    assign w_idx    = w_src_loc[AW-1:0];
    assign w_wr_idx = r_loc[AW-1:0];

    always_comb begin
        w_rd_data = '0;
        if (w_src_rd && !w_src_wr && !w_err) begin
            for (int i = 0; i < 8; i++) begin
                w_rd_data[8*i +: 8] = r_mem[w_idx + AW'(i)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_loc       <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_rd    <= read_En;
                        r_wr    <= write_En;
                        r_loc   <= location;
                        r_wdata <= wdata;
                        r_cnt   <= 4'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            r_state     <= StResp;
                            r_rsp_valid <= 1'b1;
                            r_rdata     <= w_rd_data;
                            r_err       <= w_err;
                        end else begin
                            r_state <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state     <= StResp;
                        r_rsp_valid <= 1'b1;
                        r_rdata     <= w_rd_data;
                        r_err       <= w_err;
                    end
                end
                StResp: begin
                    r_state     <= StIdle;
                    r_cnt       <= '0;
                    r_rsp_valid <= 1'b0;
                    r_rdata     <= '0;
                    r_err       <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Array has no reset; an async reset leaves StResp before this edge, dropping the write.
    always_ff @(posedge clk) begin
        if (r_state == StResp && r_wr && !r_rd && !r_err) begin
            for (int i = 0; i < 8; i++) begin
                r_mem[w_wr_idx + AW'(i)] <= r_wdata[8*i +: 8];
            end
        end
    end

    assign req_ready     = (r_state == StIdle);
    assign rsp_valid     = r_rsp_valid;
    assign rdata         = r_rdata;
    assign data_memerror = r_err;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed self-checking bench: LATENCY=2 main instance plus a LATENCY=1 instance for back-to-back.
module tb_data_memory_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        read_En;
    logic        write_En;
    logic [63:0] location;
    logic [63:0] wdata;
    logic        rsp_valid;
    logic [63:0] rdata;
    logic        data_memerror;

    logic        l1_req_valid;
    logic        l1_req_ready;
    logic        l1_rsp_valid;
    logic [63:0] l1_rdata;
    logic        l1_err;

    int n_checks;
    int n_fail;

    data_memory_responder #(
        .MEM_BYTES(1024),
        .LATENCY  (2)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .read_En      (read_En),
        .write_En     (write_En),
        .location     (location),
        .wdata        (wdata),
        .rsp_valid    (rsp_valid),
        .rdata        (rdata),
        .data_memerror(data_memerror)
    );

    data_memory_responder #(
        .MEM_BYTES(1024),
        .LATENCY  (1)
    ) u_dut_l1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (l1_req_valid),
        .req_ready    (l1_req_ready),
        .read_En      (1'b1),
        .write_En     (1'b0),
        .location     (64'h0),
        .wdata        (64'h0),
        .rsp_valid    (l1_rsp_valid),
        .rdata        (l1_rdata),
        .data_memerror(l1_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request and wait (bounded) for its response pulse.
    task automatic do_req(input logic rd, input logic wr, input logic [63:0] loc,
                          input logic [63:0] wd, output logic [63:0] rdat,
                          output logic err, output int lat);
        @(negedge clk);
        req_valid = 1'b1;
        read_En   = rd;
        write_En  = wr;
        location  = loc;
        wdata     = wd;
        @(negedge clk);
        req_valid = 1'b0;
        read_En   = 1'b0;
        write_En  = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdat = rdata;
        err  = data_memerror;
    endtask

    logic [63:0] rd_v;
    logic        err_v;
    int          lat_v;

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        read_En      = 1'b0;
        write_En     = 1'b0;
        location     = '0;
        wdata        = '0;
        l1_req_valid = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rdata", rdata, 64'd0);
        check_eq("rst_err", 64'(data_memerror), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ready_after", 64'(req_ready), 64'd1);

        // Write then read with latency check
        do_req(1'b0, 1'b1, 64'h10, 64'h1122334455667788, rd_v, err_v, lat_v);
        check_eq("wr10_lat", 64'(lat_v), 64'd2);
        check_eq("wr10_err", 64'(err_v), 64'd0);
        check_eq("wr10_rdata", rd_v, 64'd0);
        do_req(1'b1, 1'b0, 64'h10, 64'h0, rd_v, err_v, lat_v);
        check_eq("rd10_lat", 64'(lat_v), 64'd2);
        check_eq("rd10_rdata", rd_v, 64'h1122334455667788);
        check_eq("rd10_err", 64'(err_v), 64'd0);
        @(negedge clk);
        check_eq("idle_rsp_low", 64'(rsp_valid), 64'd0);
        check_eq("idle_rdata_zero", rdata, 64'd0);

        // Bounds
        do_req(1'b0, 1'b1, 64'h3F8, 64'hA5A5_0000_FFFF_1234, rd_v, err_v, lat_v);
        do_req(1'b1, 1'b0, 64'h3F8, 64'h0, rd_v, err_v, lat_v);
        check_eq("rd3f8_err", 64'(err_v), 64'd0);
        check_eq("rd3f8_rdata", rd_v, 64'hA5A5_0000_FFFF_1234);
        do_req(1'b1, 1'b0, 64'h3F9, 64'h0, rd_v, err_v, lat_v);
        check_eq("rd3f9_err", 64'(err_v), 64'd1);
        check_eq("rd3f9_rdata", rd_v, 64'd0);
        do_req(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, rd_v, err_v, lat_v);
        check_eq("rdwrap_err", 64'(err_v), 64'd1);
        check_eq("rdwrap_rdata", rd_v, 64'd0);

        // Both enables, then no enables
        do_req(1'b0, 1'b1, 64'h20, 64'hCAFE_F00D_DEAD_BEEF, rd_v, err_v, lat_v);
        do_req(1'b1, 1'b1, 64'h20, 64'h0123_4567_89AB_CDEF, rd_v, err_v, lat_v);
        check_eq("both_err", 64'(err_v), 64'd1);
        check_eq("both_rdata", rd_v, 64'd0);
        do_req(1'b1, 1'b0, 64'h20, 64'h0, rd_v, err_v, lat_v);
        check_eq("both_unchanged", rd_v, 64'hCAFE_F00D_DEAD_BEEF);
        do_req(1'b0, 1'b0, 64'h20, 64'h5555_5555_5555_5555, rd_v, err_v, lat_v);
        check_eq("none_lat", 64'(lat_v), 64'd2);
        check_eq("none_err", 64'(err_v), 64'd0);
        check_eq("none_rdata", rd_v, 64'd0);
        do_req(1'b1, 1'b0, 64'h20, 64'h0, rd_v, err_v, lat_v);
        check_eq("none_unchanged", rd_v, 64'hCAFE_F00D_DEAD_BEEF);

        // Reset abort during BUSY
        do_req(1'b0, 1'b1, 64'h40, 64'h0123_4567_89AB_CDEF, rd_v, err_v, lat_v);
        @(negedge clk);
        req_valid = 1'b1;
        write_En  = 1'b1;
        location  = 64'h40;
        wdata     = 64'hAA;
        @(negedge clk);
        req_valid = 1'b0;
        write_En  = 1'b0;
        check_eq("abort_busy_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check_eq("abort_async_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("abort_ready_after", 64'(req_ready), 64'd1);
        check_eq("abort_no_rsp0", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check_eq("abort_no_rsp1", 64'(rsp_valid), 64'd0);
        do_req(1'b1, 1'b0, 64'h40, 64'h0, rd_v, err_v, lat_v);
        check_eq("abort_busy_old", rd_v, 64'h0123_4567_89AB_CDEF);

        // Reset abort during RESP, just before the commit edge
        @(negedge clk);
        req_valid = 1'b1;
        write_En  = 1'b1;
        location  = 64'h40;
        wdata     = 64'hFEED_FACE_0000_0001;
        @(negedge clk);
        req_valid = 1'b0;
        write_En  = 1'b0;
        @(negedge clk);
        check_eq("abort_resp_seen", 64'(rsp_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_resp_cleared", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b1, 1'b0, 64'h40, 64'h0, rd_v, err_v, lat_v);
        check_eq("abort_resp_old", rd_v, 64'h0123_4567_89AB_CDEF);

        // Unaligned write at 0x13 over the earlier 0x10 contents
        do_req(1'b0, 1'b1, 64'h13, 64'h8877_6655_4433_2211, rd_v, err_v, lat_v);
`ifdef DMEM_ALIGN_CHECK_EN
        check_eq("unal_wr_err", 64'(err_v), 64'd1);
        do_req(1'b1, 1'b0, 64'h10, 64'h0, rd_v, err_v, lat_v);
        check_eq("unal_mem_kept", rd_v, 64'h1122334455667788);
`else
        check_eq("unal_wr_err", 64'(err_v), 64'd0);
        do_req(1'b1, 1'b0, 64'h13, 64'h0, rd_v, err_v, lat_v);
        check_eq("unal_readback", rd_v, 64'h8877_6655_4433_2211);
        do_req(1'b1, 1'b0, 64'h10, 64'h0, rd_v, err_v, lat_v);
        check_eq("unal_overlap", rd_v, 64'h5544_3322_1166_7788);
`endif

        // Back-to-back on the LATENCY=1 instance
        @(negedge clk);
        check_eq("l1_ready_idle", 64'(l1_req_ready), 64'd1);
        l1_req_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq($sformatf("l1_ready_%0d", k), 64'(l1_req_ready), 64'(k % 2));
            check_eq($sformatf("l1_rsp_%0d", k), 64'(l1_rsp_valid), 64'((k + 1) % 2));
        end
        l1_req_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
